cordic_vector: RTL and testbench

- Iterative vectoring-mode CORDIC: the inverse direction of the rotation-mode trig core.
- Takes a first-octant vector (x, y) in unsigned Q0.32 and returns atan(y/x) in Q0.32 radians and the gain-corrected magnitude sqrt(x²+y²).
- Uses the same arctangent table Theta[i] = atan(2^-i)·2^32 and the same cumulative-gain table Prd_K[i] as the rotation core.
- Sits beside the trig core in the calculator datapath and is driven through a valid/ready handshake.

---
 rtl/cordic_vector.sv | 166 ++++++++++++++++
 tb/tb_cordic_vector.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: returns atan(y/x) and the gain-corrected
// magnitude of a first-octant Q0.32 vector behind a valid/ready handshake.
module cordic_vector #(
    parameter int ITER = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] angle,
    output logic [31:0] magnitude,
    output logic        out_err
);

    localparam logic [1:0] stIdle  = 2'd0;
    localparam logic [1:0] stIter  = 2'd1;
    localparam logic [1:0] stScale = 2'd2;
    localparam logic [1:0] stDone  = 2'd3;

    function automatic logic [31:0] theta(input logic [2:0] i);
        logic [31:0] t;
        case (i)
            3'd0:    t = 32'hC90FDAA2;
            3'd1:    t = 32'h76B19C16;
            3'd2:    t = 32'h3EB6EBF2;
            3'd3:    t = 32'h1FD5BA9A;
            3'd4:    t = 32'h0FFAADDB;
            3'd5:    t = 32'h07FF556E;
            3'd6:    t = 32'h03FFEAAB;
            default: t = 32'h01FFFD55;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] prdK(input int n);
        logic [31:0] k;
        case (n)
            0:       k = 32'hB504F334;
            1:       k = 32'hA1E89B13;
            2:       k = 32'h9D130DD4;
            3:       k = 32'h9BDC8A0F;
            4:       k = 32'h9B8ED60C;
            5:       k = 32'h9B7B67D6;
            6:       k = 32'h9B768C35;
            default: k = 32'h9B75554B;
        endcase
        return k;
    endfunction

    localparam logic [31:0] kScale  = prdK(ITER - 1);
    localparam logic [2:0]  lastCnt = 3'(ITER - 1);

    logic [1:0]         state;
    logic signed [34:0] xr;
    logic signed [34:0] yr;
    logic signed [33:0] zr;
    logic [2:0]         cnt;
    logic               outValidR;
    logic               errR;
    logic [31:0]        angleR;
    logic [31:0]        magR;

    logic signed [34:0] xSh;
    logic signed [34:0] ySh;
    logic signed [34:0] xNext;
    logic signed [34:0] yNext;
    logic signed [33:0] zNext;
    logic signed [33:0] thetaExt;
    logic [34:0]        scaled;
    logic [31:0]        magNext;
    logic [31:0]        angleNext;

    always_comb begin
        xSh      = xr >>> cnt;
        ySh      = yr >>> cnt;
        thetaExt = {2'b00, theta(cnt)};
        if (!yr[34]) begin
            xNext = xr + ySh;
            yNext = yr - xSh;
            zNext = zr + thetaExt;
        end else begin
            xNext = xr - ySh;
            yNext = yr + xSh;
            zNext = zr - thetaExt;
        end
        scaled  = 35'(({32'd0, xr} * {35'd0, kScale}) >> 32);
        magNext = (|scaled[34:32]) ? 32'hFFFFFFFF : scaled[31:0];
        // A zero vector has no direction; report 0 rather than the table sum.
        if (xr == '0) begin
            angleNext = '0;
        end else if (zr[33]) begin
            angleNext = '0;
        end else if (zr[32]) begin
            angleNext = 32'hFFFFFFFF;
        end else begin
            angleNext = zr[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= stIdle;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            cnt       <= '0;
            outValidR <= 1'b0;
            errR      <= 1'b0;
            angleR    <= '0;
            magR      <= '0;
        end else begin
            case (state)
                stIdle: begin
                    if (in_valid) begin
                        if (y_in > x_in) begin
                            errR   <= 1'b1;
                            angleR <= '0;
                            magR   <= '0;
                            state  <= stDone;
                        end else begin
                            xr    <= {3'b000, x_in};
                            yr    <= {3'b000, y_in};
                            zr    <= '0;
                            cnt   <= '0;
                            state <= stIter;
                        end
                    end
                end
                stIter: begin
                    xr  <= xNext;
                    yr  <= yNext;
                    zr  <= zNext;
                    cnt <= cnt + 3'd1;
                    if (cnt == lastCnt) begin
                        state <= stScale;
                    end
                end
                stScale: begin
                    angleR <= angleNext;
                    magR   <= magNext;
                    errR   <= 1'b0;
                    state  <= stDone;
                end
                default: begin
                    if (!outValidR) begin
                        outValidR <= 1'b1;
                    end else if (out_ready) begin
                        outValidR <= 1'b0;
                        state     <= stIdle;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state == stIdle);
    assign out_valid = outValidR;
    assign angle     = angleR;
    assign magnitude = magR;
    assign out_err   = errR;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: real-valued reference model checked on every
// valid cycle, plus directed vectors with hand-computed bounds.
module tb_cordic_vector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        inValid  [2];
    logic        outReady [2];
    logic [31:0] xIn      [2];
    logic [31:0] yIn      [2];
    logic        inReady  [2];
    logic        outValid [2];
    logic        outErr   [2];
    logic [31:0] angle    [2];
    logic [31:0] mag      [2];

    int tests = 0;
    int fails = 0;

    cordic_vector #(.ITER(8)) dut8 (
        .clk(clk), .reset_n(rstN),
        .in_valid(inValid[0]), .in_ready(inReady[0]),
        .x_in(xIn[0]), .y_in(yIn[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .angle(angle[0]), .magnitude(mag[0]), .out_err(outErr[0])
    );

    cordic_vector #(.ITER(4)) dut4 (
        .clk(clk), .reset_n(rstN),
        .in_valid(inValid[1]), .in_ready(inReady[1]),
        .x_in(xIn[1]), .y_in(yIn[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .angle(angle[1]), .magnitude(mag[1]), .out_err(outErr[1])
    );

    task automatic check(input string name, input bit ok,
                         input longint act, input longint req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic bit near(input longint a, input longint b,
                                input longint tol);
        return (a - b <= tol) && (b - a <= tol);
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Ideal result with the allowed error for an ITER-step core.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  input int it, output bit eErr,
                                  output real eAng, output real tAng,
                                  output real eMag, output real tMag);
        real two32 = 4294967296.0;
        real rx = real'(longint'({32'd0, x}));
        real ry = real'(longint'({32'd0, y}));
        real r  = $sqrt(rx * rx + ry * ry);
        eErr = (y > x);
        eAng = (rx == 0.0) ? 0.0 : $atan(ry / rx) * two32;
        tAng = (rx == 0.0) ? 0.0 : $atan(2.0 ** real'(1 - it)) * two32 + 16.0;
        eMag = (r > 4294967295.0) ? 4294967295.0 : r;
        tMag = eMag * (2.0 ** real'(1 - it)) + 16.0;
        if (eErr) begin
            eAng = 0.0;
            tAng = 0.0;
            eMag = 0.0;
            tMag = 0.0;
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int IT = (g == 0) ? 8 : 4;
        logic [63:0] q[$];
        always @(negedge clk) begin
            bit  eErr;
            real eAng, tAng, eMag, tMag;
            if (!rstN) begin
                q.delete();
            end else begin
                if (outValid[g]) begin
                    if (q.size() == 0) begin
                        check("spurious_valid", 1'b0, 1, 0);
                    end else begin
                        model(q[0][63:32], q[0][31:0], IT,
                              eErr, eAng, tAng, eMag, tMag);
                        check("model_err", outErr[g] == eErr,
                              longint'(outErr[g]), longint'(eErr));
                        check("model_angle",
                              rabs(real'(angle[g]) - eAng) <= tAng,
                              longint'(angle[g]), longint'(eAng));
                        check("model_mag",
                              rabs(real'(mag[g]) - eMag) <= tMag,
                              longint'(mag[g]), longint'(eMag));
                        if (outReady[g]) void'(q.pop_front());
                    end
                end
                if (inValid[g] && inReady[g]) q.push_back({xIn[g], yIn[g]});
            end
        end
    end

    task automatic sendOp(input int k, input logic [31:0] x,
                          input logic [31:0] y, output int lat, output int wt);
        wt = 0;
        while (!inReady[k] && wt < 100) begin
            @(posedge clk);
            #1;
            wt++;
        end
        if (wt >= 100) check("accept_timeout", 1'b0, wt, 0);
        xIn[k]     = x;
        yIn[k]     = y;
        inValid[k] = 1'b1;
        @(posedge clk);
        #1;
        inValid[k] = 1'b0;
        lat = 0;
        while (!outValid[k] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic takeResult(input int k);
        outReady[k] = 1'b1;
        @(posedge clk);
        #1;
        outReady[k] = 1'b0;
    endtask

    int          lat;
    int          wt;
    logic [31:0] sa;
    logic [31:0] sm;
    logic [31:0] rx;
    logic [31:0] ry;
    bit          pErr;
    real         pAng, pTA, pMag, pTM;

    initial begin
        rstN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            inValid[k]  = 1'b0;
            outReady[k] = 1'b0;
            xIn[k]      = '0;
            yIn[k]      = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        check("rst_angle", angle[0] == 0, angle[0], 0);
        check("rst_mag", mag[0] == 0, mag[0], 0);
        check("rst_err", outErr[0] == 0, outErr[0], 0);
        check("rst_valid", outValid[0] == 0, outValid[0], 0);
        check("rst_ready", inReady[0] == 1, inReady[0], 1);
        check("rst_ready4", inReady[1] == 1, inReady[1], 1);

        model(32'h80000000, 32'h80000000, 8, pErr, pAng, pTA, pMag, pTM);
        check("pin_ang45", near(longint'(pAng), 64'd3373259426, 2),
              longint'(pAng), 64'd3373259426);
        check("pin_mag45", near(longint'(pMag), 64'd3037000500, 2),
              longint'(pMag), 64'd3037000500);
        check("pin_tol8", near(longint'(pTA), 64'd33553765, 2),
              longint'(pTA), 64'd33553765);
        model(32'h40000000, 32'h40000000, 8, pErr, pAng, pTA, pMag, pTM);
        check("pin_mag40", near(longint'(pMag), 64'd1518500250, 2),
              longint'(pMag), 64'd1518500250);

        sendOp(0, 32'h80000000, 32'h0, lat, wt);
        check("first_accept", wt == 0, wt, 0);
        check("lat_norm", lat == 10, lat, 10);
        check("y0_angle", angle[0] <= 32'h02000000, angle[0], 32'h02000000);
        check("y0_mag", near(mag[0], 32'h80000000, 32'h01000000 + 16),
              mag[0], 32'h80000000);
        check("y0_err", outErr[0] == 0, outErr[0], 0);
        takeResult(0);

        sendOp(0, 32'h80000000, 32'h80000000, lat, wt);
        check("lat_45", lat == 10, lat, 10);
        check("d45_angle", near(angle[0], 32'hC90FDAA2, 32'h02000000),
              angle[0], 32'hC90FDAA2);
        check("d45_mag", near(mag[0], 32'hB504F333, 32'h016A09E6 + 16),
              mag[0], 32'hB504F333);
        takeResult(0);

        sendOp(0, 32'h10000000, 32'h20000000, lat, wt);
        check("lat_err", lat == 1, lat, 1);
        check("err_flag", outErr[0] == 1, outErr[0], 1);
        check("err_angle", angle[0] == 0, angle[0], 0);
        check("err_mag", mag[0] == 0, mag[0], 0);
        takeResult(0);

        sendOp(0, 32'h0, 32'h0, lat, wt);
        check("zero_angle", angle[0] == 0, angle[0], 0);
        check("zero_mag", mag[0] == 0, mag[0], 0);
        check("zero_err", outErr[0] == 0, outErr[0], 0);
        takeResult(0);

        sendOp(0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, wt);
        check("sat_mag", mag[0] == 32'hFFFFFFFF, mag[0], 32'hFFFFFFFF);
        check("sat_angle", near(angle[0], 32'hC90FDAA2, 32'h02000000),
              angle[0], 32'hC90FDAA2);
        takeResult(0);

        sendOp(0, 32'h60000000, 32'h20000000, lat, wt);
        sa = angle[0];
        sm = mag[0];
        for (int c = 0; c < 5; c++) begin
            inValid[0] = 1'b1;
            xIn[0]     = 32'h12345678 + 32'(c);
            yIn[0]     = 32'h00001000;
            @(posedge clk);
            #1;
            check("bp_ready", inReady[0] == 0, inReady[0], 0);
            check("bp_valid", outValid[0] == 1, outValid[0], 1);
            check("bp_angle", angle[0] == sa, angle[0], sa);
            check("bp_mag", mag[0] == sm, mag[0], sm);
        end
        inValid[0] = 1'b0;
        takeResult(0);
        check("bp_idle_valid", outValid[0] == 0, outValid[0], 0);
        check("bp_idle_ready", inReady[0] == 1, inReady[0], 1);
        sendOp(0, 32'h30000000, 32'h10000000, lat, wt);
        check("b2b_accept", wt == 0, wt, 0);
        check("b2b_lat", lat == 10, lat, 10);
        takeResult(0);

        xIn[0]     = 32'h70000000;
        yIn[0]     = 32'h50000000;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rstN = 1'b0;
        #2;
        check("mid_rst_valid", outValid[0] == 0, outValid[0], 0);
        check("mid_rst_angle", angle[0] == 0, angle[0], 0);
        check("mid_rst_mag", mag[0] == 0, mag[0], 0);
        check("mid_rst_err", outErr[0] == 0, outErr[0], 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        check("mid_rst_ready", inReady[0] == 1, inReady[0], 1);
        sendOp(0, 32'h40000000, 32'h40000000, lat, wt);
        check("post_rst_angle", near(angle[0], 32'hC90FDAA2, 32'h02000000),
              angle[0], 32'hC90FDAA2);
        check("post_rst_mag", near(mag[0], 32'h5A827999, 32'h00B504F3 + 16),
              mag[0], 32'h5A827999);
        takeResult(0);

        sendOp(1, 32'h80000000, 32'h80000000, lat, wt);
        check("lat_iter4", lat == 6, lat, 6);
        check("i4_angle", near(angle[1], 32'hC90FDAA2, 32'h1FD5BA9A + 16),
              angle[1], 32'hC90FDAA2);
        takeResult(1);

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 1000; n++) begin
                rx = $urandom >> $urandom_range(0, 15);
                if (rx < 32'h00010000) rx = rx + 32'h00010000;
                ry = 32'(64'($urandom) % (64'(rx) + 64'd1));
                sendOp(k, rx, ry, lat, wt);
                check("sweep_lat", lat == ((k == 0) ? 10 : 6), lat,
                      (k == 0) ? 10 : 6);
                takeResult(k);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
